// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding controller for a 5-stage IF/ID/EX/ME/WB pipeline.
// Control outputs are combinational; state, counters and mem_err are registered.
module pipe_hazard_ctrl #(
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int MEM_TIMEOUT         = 64,
   parameter int CNT_BITS            = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs1,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs2,
   input  logic                           id_use_rs1,
   input  logic                           id_use_rs2,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
   input  logic                           ex_wrReg,
   input  logic                           ex_isLoad,
   input  logic                           ex_br_taken,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] me_rd,
   input  logic                           me_wrReg,
   input  logic                           mem_req,
   input  logic                           mem_ready,
   output logic                           pc_wrt_en,
   output logic                           if_wrt_en,
   output logic                           id_wrt_en,
   output logic                           ex_wrt_en,
   output logic                           me_wrt_en,
   output logic                           if_flush,
   output logic                           id_flush,
   output logic [1:0]                     fwd_a,
   output logic [1:0]                     fwd_b,
   output logic [1:0]                     state,
   output logic                           mem_err,
   output logic [CNT_BITS-1:0]            stall_cycles,
   output logic [CNT_BITS-1:0]            flush_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   localparam logic [15:0]         TIMEOUT = 16'(MEM_TIMEOUT);
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   state_t              state_reg, state_next;
   logic [15:0]         wait_cnt_reg, wait_cnt_next;
   logic                mem_err_reg, mem_err_next;
   logic [CNT_BITS-1:0] stall_cnt_reg, stall_cnt_next;
   logic [CNT_BITS-1:0] flush_cnt_reg, flush_cnt_next;

   logic memwait, redirect, loaduse;

   assign memwait  = mem_req & ~mem_ready;
   assign redirect = ex_br_taken;
   assign loaduse  = ex_isLoad & ex_wrReg &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      pc_wrt_en  = 1'b1;
      if_wrt_en  = 1'b1;
      id_wrt_en  = 1'b1;
      ex_wrt_en  = 1'b1;
      me_wrt_en  = 1'b1;
      if_flush   = 1'b0;
      id_flush   = 1'b0;
      state_next = RUN;
      if (!reset) begin
         if (memwait) begin
            pc_wrt_en  = 1'b0;
            if_wrt_en  = 1'b0;
            id_wrt_en  = 1'b0;
            ex_wrt_en  = 1'b0;
            me_wrt_en  = 1'b0;
            state_next = MEM_WAIT;
         end else if (redirect) begin
            // The ID instruction is squashed, so a coincident load-use needs no stall.
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            state_next = FLUSH;
         end else if (loaduse) begin
            pc_wrt_en  = 1'b0;
            if_wrt_en  = 1'b0;
            id_flush   = 1'b1;
            state_next = LOAD_STALL;
         end
      end
   end

   // Operand forwarding: EX result wins over ME; loads in EX cannot forward yet.
   logic [1:0][REG_INDEX_BIT_WIDTH-1:0] rs_idx;
   logic [1:0][1:0]                     fwd_sel;

   assign rs_idx[0] = id_rs1;
   assign rs_idx[1] = id_rs2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_sel[gi] = reset                                         ? 2'b00 :
                              (ex_wrReg & ~ex_isLoad & (ex_rd == rs_idx[gi])) ? 2'b01 :
                              (me_wrReg & (me_rd == rs_idx[gi]))             ? 2'b10 :
                                                                               2'b00;
      end
   endgenerate

   assign fwd_a = fwd_sel[0];
   assign fwd_b = fwd_sel[1];

   always_comb begin
      wait_cnt_next  = 16'd0;
      mem_err_next   = mem_err_reg;
      stall_cnt_next = stall_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      if (memwait) begin
         wait_cnt_next = (wait_cnt_reg < TIMEOUT) ? wait_cnt_reg + 16'd1 : wait_cnt_reg;
         if (wait_cnt_reg >= TIMEOUT - 16'd1)
            mem_err_next = 1'b1;
      end
      if (!pc_wrt_en && stall_cnt_reg != CNT_MAX)
         stall_cnt_next = stall_cnt_reg + 1'b1;
      if (redirect && !memwait && flush_cnt_reg != CNT_MAX)
         flush_cnt_next = flush_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= RUN;
         wait_cnt_reg  <= 16'd0;
         mem_err_reg   <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         mem_err_reg   <= mem_err_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   assign state        = state_reg;
   assign mem_err      = mem_err_reg;
   assign stall_cycles = stall_cnt_reg;
   assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl, built with MEM_TIMEOUT=4 and CNT_BITS=4
// so that timeout and counter saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

   localparam int RW = 4;
   localparam int CB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd, me_rd;
   logic          id_use_rs1, id_use_rs2, ex_wrReg, ex_isLoad, ex_br_taken;
   logic          me_wrReg, mem_req, mem_ready;
   logic          pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en;
   logic          if_flush, id_flush, mem_err;
   logic [1:0]    fwd_a, fwd_b, state;
   logic [CB-1:0] stall_cycles, flush_count;

   int n_cmp = 0;
   int n_err = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   pipe_hazard_ctrl #(
      .REG_INDEX_BIT_WIDTH(RW),
      .MEM_TIMEOUT(4),
      .CNT_BITS(CB)
   ) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_wrReg(ex_wrReg), .ex_isLoad(ex_isLoad), .ex_br_taken(ex_br_taken),
      .me_rd(me_rd), .me_wrReg(me_wrReg), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_wrt_en(pc_wrt_en), .if_wrt_en(if_wrt_en), .id_wrt_en(id_wrt_en),
      .ex_wrt_en(ex_wrt_en), .me_wrt_en(me_wrt_en),
      .if_flush(if_flush), .id_flush(id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .state(state), .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = '0; ex_wrReg = 0; ex_isLoad = 0; ex_br_taken = 0;
      me_rd = '0; me_wrReg = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      // Load-use, memwait and ME match all present: reset must override them.
      ex_isLoad = 1; ex_wrReg = 1; ex_rd = 4'd2; id_use_rs1 = 1; id_rs1 = 4'd2;
      me_wrReg = 1; me_rd = 4'd2; mem_req = 1;
      #1;
      if ({pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en} !== 5'b11111) begin
         $display("FAIL reset_en got %b want 11111", {pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en}); n_err++;
      end
      n_cmp++;
      if ({if_flush, id_flush, fwd_a, fwd_b} !== 6'b0) begin
         $display("FAIL reset_flush_fwd got %b want 000000", {if_flush, id_flush, fwd_a, fwd_b}); n_err++;
      end
      n_cmp++;
      tick();
      tick();
      if ({state, mem_err, stall_cycles, flush_count} !== 11'b0) begin
         $display("FAIL reset_regs state=%0d err=%b stall=%0d flush=%0d want 0", state, mem_err, stall_cycles, flush_count); n_err++;
      end
      n_cmp++;
      idle();
      reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_load_use();
      ex_isLoad = 1; ex_wrReg = 1; ex_rd = 4'd5; id_use_rs1 = 1; id_rs1 = 4'd5;
      #1;
      if ({pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush} !== 7'b0011101) begin
         $display("FAIL lu_ctrl got %b want 0011101", {pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush}); n_err++;
      end
      n_cmp++;
      if (fwd_a !== 2'b00) begin
         $display("FAIL lu_fwd_a got %b want 00", fwd_a); n_err++;
      end
      n_cmp++;
      tick(); exp_stall++;
      if (state !== 2'd1) begin
         $display("FAIL lu_state got %0d want 1", state); n_err++;
      end
      n_cmp++;
      // Bubble now in EX; the load has moved to ME.
      ex_isLoad = 0; ex_wrReg = 0; me_rd = 4'd5; me_wrReg = 1;
      #1;
      if ({pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush} !== 7'b1111100) begin
         $display("FAIL lu_release got %b want 1111100", {pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush}); n_err++;
      end
      n_cmp++;
      if (fwd_a !== 2'b10 || stall_cycles !== CB'(exp_stall)) begin
         $display("FAIL lu_after fwd_a=%b stall=%0d want 10 %0d", fwd_a, stall_cycles, exp_stall); n_err++;
      end
      n_cmp++;
      tick();
      // rs2 hazard, then a matching rs2 that is not actually read.
      idle();
      ex_isLoad = 1; ex_wrReg = 1; ex_rd = 4'd7; id_rs2 = 4'd7; id_use_rs2 = 1;
      #1;
      if (pc_wrt_en !== 1'b0) begin
         $display("FAIL lu_rs2 pc_wrt_en got %b want 0", pc_wrt_en); n_err++;
      end
      n_cmp++;
      tick(); exp_stall++;
      id_use_rs2 = 0;
      #1;
      if (pc_wrt_en !== 1'b1 || id_flush !== 1'b0) begin
         $display("FAIL lu_unused pc=%b id_flush=%b want 1 0", pc_wrt_en, id_flush); n_err++;
      end
      n_cmp++;
      tick();
      if (state !== 2'd0 || stall_cycles !== CB'(exp_stall)) begin
         $display("FAIL lu_end state=%0d stall=%0d want 0 %0d", state, stall_cycles, exp_stall); n_err++;
      end
      n_cmp++;
      idle();
      $display("test_load_use done");
   endtask

   task automatic test_forwarding();
      ex_rd = 4'd3; me_rd = 4'd3; ex_wrReg = 1; me_wrReg = 1; id_rs2 = 4'd3; id_rs1 = 4'd9;
      #1;
      if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin
         $display("FAIL fwd_ex fwd_b=%b fwd_a=%b want 01 00", fwd_b, fwd_a); n_err++;
      end
      n_cmp++;
      ex_wrReg = 0;
      #1;
      if (fwd_b !== 2'b10) begin
         $display("FAIL fwd_me got %b want 10", fwd_b); n_err++;
      end
      n_cmp++;
      id_rs2 = 4'd4;
      #1;
      if (fwd_b !== 2'b00) begin
         $display("FAIL fwd_none got %b want 00", fwd_b); n_err++;
      end
      n_cmp++;
      // Register 0 is an ordinary register; a load in EX does not forward.
      id_rs1 = 4'd0; me_rd = 4'd0; ex_rd = 4'd0; ex_wrReg = 1; ex_isLoad = 1;
      #1;
      if (fwd_a !== 2'b10) begin
         $display("FAIL fwd_r0_load got %b want 10", fwd_a); n_err++;
      end
      n_cmp++;
      id_rs1 = 4'd15; ex_rd = 4'd15; ex_isLoad = 0;
      #1;
      if (fwd_a !== 2'b01) begin
         $display("FAIL fwd_r15 got %b want 01", fwd_a); n_err++;
      end
      n_cmp++;
      idle();
      $display("test_forwarding done");
   endtask

   task automatic test_redirect();
      ex_br_taken = 1; ex_isLoad = 1; ex_wrReg = 1; ex_rd = 4'd6; id_use_rs1 = 1; id_rs1 = 4'd6;
      #1;
      if ({pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush} !== 7'b1111111) begin
         $display("FAIL br_ctrl got %b want 1111111", {pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush}); n_err++;
      end
      n_cmp++;
      tick(); exp_flush++;
      if (state !== 2'd2 || flush_count !== CB'(exp_flush) || stall_cycles !== CB'(exp_stall)) begin
         $display("FAIL br_regs state=%0d flush=%0d stall=%0d want 2 %0d %0d", state, flush_count, stall_cycles, exp_flush, exp_stall); n_err++;
      end
      n_cmp++;
      idle();
      ex_br_taken = 1;
      tick(); exp_flush++;
      if (state !== 2'd2 || flush_count !== CB'(exp_flush)) begin
         $display("FAIL br_b2b state=%0d flush=%0d want 2 %0d", state, flush_count, exp_flush); n_err++;
      end
      n_cmp++;
      idle();
      tick();
      if (state !== 2'd0) begin
         $display("FAIL br_end state got %0d want 0", state); n_err++;
      end
      n_cmp++;
      $display("test_redirect done");
   endtask

   task automatic test_mem_wait();
      for (int rep = 0; rep < 2; rep++) begin
         mem_req = 1; mem_ready = 0; ex_br_taken = 1;
         for (int i = 0; i < 3; i++) begin
            #1;
            if ({pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush} !== 7'b0) begin
               $display("FAIL mw_ctrl rep=%0d cyc=%0d got %b want 0000000", rep, i, {pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en, if_flush, id_flush}); n_err++;
            end
            n_cmp++;
            tick(); exp_stall++;
            if (state !== 2'd3) begin
               $display("FAIL mw_state rep=%0d cyc=%0d got %0d want 3", rep, i, state); n_err++;
            end
            n_cmp++;
         end
         ex_br_taken = 0; mem_ready = 1;
         #1;
         if ({pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en} !== 5'b11111) begin
            $display("FAIL mw_ready got %b want 11111", {pc_wrt_en, if_wrt_en, id_wrt_en, ex_wrt_en, me_wrt_en}); n_err++;
         end
         n_cmp++;
         tick();
         if (state !== 2'd0 || stall_cycles !== CB'(exp_stall) || mem_err !== 1'b0 || flush_count !== CB'(exp_flush)) begin
            $display("FAIL mw_end state=%0d stall=%0d err=%b flush=%0d want 0 %0d 0 %0d", state, stall_cycles, mem_err, flush_count, exp_stall, exp_flush); n_err++;
         end
         n_cmp++;
         idle();
      end
      $display("test_mem_wait done");
   endtask

   task automatic test_timeout();
      mem_req = 1; mem_ready = 0;
      for (int k = 1; k <= 6; k++) begin
         tick(); exp_stall++;
         if (mem_err !== (k >= 4)) begin
            $display("FAIL to_err cyc=%0d got %b want %b", k, mem_err, (k >= 4)); n_err++;
         end
         n_cmp++;
      end
      mem_ready = 1;
      tick();
      if (mem_err !== 1'b1 || state !== 2'd0 || stall_cycles !== CB'(exp_stall)) begin
         $display("FAIL to_sticky err=%b state=%0d stall=%0d want 1 0 %0d", mem_err, state, stall_cycles, exp_stall); n_err++;
      end
      n_cmp++;
      idle();
      mem_req = 1;
      tick();
      reset = 1;
      tick();
      reset = 0;
      idle();
      exp_stall = 0; exp_flush = 0;
      if ({state, mem_err, stall_cycles, flush_count} !== 11'b0) begin
         $display("FAIL to_reset state=%0d err=%b stall=%0d flush=%0d want 0", state, mem_err, stall_cycles, flush_count); n_err++;
      end
      n_cmp++;
      $display("test_timeout done");
   endtask

   task automatic test_saturation();
      ex_br_taken = 1;
      repeat (20) tick();
      if (flush_count !== 4'd15) begin
         $display("FAIL sat_flush got %0d want 15", flush_count); n_err++;
      end
      n_cmp++;
      idle();
      mem_req = 1;
      repeat (20) tick();
      if (stall_cycles !== 4'd15 || flush_count !== 4'd15) begin
         $display("FAIL sat_stall stall=%0d flush=%0d want 15 15", stall_cycles, flush_count); n_err++;
      end
      n_cmp++;
      idle();
      tick();
      $display("test_saturation done");
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #2;
      test_reset();
      test_load_use();
      test_forwarding();
      test_redirect();
      test_mem_wait();
      test_timeout();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
